// File: rtl/fifo_ser_pkg.sv
// Shared constants and the serializer state type for the FIFO read serializer.
package fifo_ser_pkg;

  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 4;
  localparam int IDX_W     = $clog2(NUM_BYTES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    LOAD,
    SEND
  } ser_state_t;

endpackage

// File: rtl/ser_byte_sel.sv
// Byte selection for the serializer: holds the popped word, shifts it a byte per
// accepted transfer and tracks the byte index within the word.
module ser_byte_sel
  import fifo_ser_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [WORD_W-1:0] load_data,
  output logic [BYTE_W-1:0] out_data,
  output logic [IDX_W-1:0]  index
);

  logic [WORD_W-1:0] shift_q;
  logic [IDX_W-1:0]  index_q;

  // The outgoing byte always sits at the end of the register facing the sink,
  // so selection is a fixed slice rather than an index-driven mux.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shift_q <= '0;
      index_q <= '0;
    end else if (load) begin
      shift_q <= load_data;
      index_q <= '0;
    end else if (advance) begin
      shift_q <= (LSB_FIRST != 0) ? (shift_q >> BYTE_W) : (shift_q << BYTE_W);
      index_q <= index_q + IDX_W'(1);
    end
  end

  assign out_data = (LSB_FIRST != 0) ? shift_q[BYTE_W-1:0]
                                     : shift_q[WORD_W-1 -: BYTE_W];
  assign index    = index_q;

endmodule

// File: rtl/fifo_read_serializer.sv
// Pops 32-bit words from a sync FIFO and streams them out as bytes with a
// valid/ready handshake. Define FIFO_READ_SERIALIZER_PARITY_EN to add out_parity.
module fifo_read_serializer
  import fifo_ser_pkg::*;
#(
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic              fifo_wr_busy,
  input  logic [WORD_W-1:0] fifo_data,
  output logic              fifo_rn,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
`ifdef FIFO_READ_SERIALIZER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  ser_state_t       state, state_nxt;
  logic [IDX_W-1:0] index;
  logic             handshake;

  // NOTE: reset is sampled on the clock edge like any other input, and all
  // registers use non-blocking assignments so they update together.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    fifo_rn   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (!fifo_empty) state_nxt = POP;
      end
      POP: begin
        fifo_rn = 1'b1;
        // A concurrent FIFO write wins, so keep requesting until the read lands.
        if (!fifo_empty && !fifo_wr_busy) state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && (index == LAST_IDX)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign handshake = out_valid && out_ready;
  assign out_last  = out_valid && (index == LAST_IDX);

  ser_byte_sel #(
    .LSB_FIRST (LSB_FIRST)
  ) u_byte_sel (
    .clock     (clock),
    .reset     (reset),
    .load      (state == LOAD),
    .advance   (handshake),
    .load_data (fifo_data),
    .out_data  (out_data),
    .index     (index)
  );

  always_ff @(posedge clock) begin
    if (!reset)                    word_count <= '0;
    else if (handshake && out_last) word_count <= word_count + CNT_W'(1);
  end

`ifdef FIFO_READ_SERIALIZER_PARITY_EN
  assign out_parity = out_valid & (^out_data);
`endif

endmodule
